sine_diff_gen: RTL
==================

# sine_diff_gen

Parametrised sine sample generator that rebuilds a full-wave sine by walking a quarter-wave difference table and accumulating its entries. It drives the address of an external combinational difference ROM and reads back the increment. It produces signed samples at a programmable phase step, with a valid/ready output handshake. It sits between the difference ROM and downstream DSP/DAC logic, and supersedes fixed-step quarter-wave lookup.

## Interface
- ADDR_W, 9: ROM address width; table length N = 2^ADDR_W; period = 4N phase positions
- DIFF_W, 16: ROM word width (unsigned increments)
- MAG_W, 16: magnitude accumulator width; the table sum S must be ≤ 2^MAG_W−1 (not checked; overflow wraps)
- clk  in  1  clock; single clock domain
- rst  in  1  synchronous reset, active-high
- en  in  1  enable; starts/resumes sample generation
- restart  in  1  synchronous phase clear to position 0
- step  in  ADDR_W+2  phase positions per output sample; 0 treated as 1
- rom_adrs  out  ADDR_W  difference ROM address (combinational ROM, same-cycle data)
- rom_diff  in  DIFF_W  difference ROM data
- sample  out  MAG_W+1  signed two's-complement sine sample
- sample_valid  out  1  sample is valid
- sample_ready  in  1  downstream accepts the sample
- quadrant  out  2  quadrant of the phase position of the current `sample`

## Operation
- Phase position p = {q[1:0], i[ADDR_W−1:0]}, p in 0..4N−1, wraps modulo 4N.
- Magnitude `mag` is unsigned MAG_W. At p = 0, mag = 0.
- Advance by one position:
  - q even: rom_adrs = i; mag += rom_diff
  - q odd: rom_adrs = N−1−i; mag −= rom_diff
  - then p += 1
- Resulting magnitudes:
  - mag(q0,i) = sum D[0..i−1]
  - mag(q1,0) = S (peak)
  - mag(q1,i) = mag(q0,N−i)
  - mag(q2,0) = 0
- Output value: sample = +mag for q ∈ {0,1}, −mag for q ∈ {2,3}, sign-extended to MAG_W+1. quadrant = q of the presented sample.
- FSM states: IDLE, OUT, WALK.
  - IDLE: sample_valid = 0. If en = 1, go to OUT; the sample register already holds the value at the current p.
  - OUT: sample_valid = 1; sample is held stable.
    - On sample_valid & sample_ready: latch step_r = (step == 0 ? 1 : step), load counter = step_r, go to WALK.
    - Else if en = 0: go to IDLE. The sample is not lost; it is re-presented on re-enable.
  - WALK: one advance per cycle; counter decrements. After the last advance, load sample/quadrant from the new p and go to OUT. en is ignored until the walk completes.
- step is sampled only at the handshake; changes mid-walk take effect on the next sample.
- rom_adrs is driven from the current p in every state. It is only consumed in WALK.
- restart = 1 (any state): next cycle p = 0, mag = 0, sample = 0, quadrant = 0, state = IDLE, sample_valid = 0. Priority: rst > restart > FSM.

## Timing
- Reset values: sample = 0, sample_valid = 0, quadrant = 0, rom_adrs = 0, internal p = 0, mag = 0, state = IDLE.
- IDLE → OUT: sample_valid rises on the first edge with en = 1.
- Handshake at edge E0 → sample_valid = 0 after E0. Advances occur at edges E1..E_step_r. The new sample and sample_valid = 1 appear after E_step_r.
- Gap between accepted samples is step_r cycles; maximum rate is one sample per step_r+1 cycles.
- sample, quadrant and sample_valid are all registered; rom_adrs is a registered-state decode.
- While sample_valid = 1 and sample_ready = 0, sample and quadrant hold indefinitely.
- Reset or restart mid-WALK aborts the walk in the same edge. Partial accumulation is discarded.
- Wrap: an advance from p = 4N−1 goes to p = 0. For an exact table, mag returns to 0 there.

## Test plan
Common bench setup: ADDR_W=3 (N=8, period 32), model ROM returns 1 at every address (S=8), sample_ready tied high unless stated.

- **Unit step.** rst then en=1, step=1. Expect sample sequence 0,1,…,7,8,7,…,1,0,−1,…,−8,…,−1,0 (33 samples). quadrant steps 0,1,2,3,0. Each sample_valid pulse is separated by 1 idle cycle.
- **Step 3.** step=3. Expect samples 0,3,6,7,4,1,−2, which are positions 0,3,6,9,12,15,18. sample_valid is low for exactly 3 cycles after each handshake.
- **Step N and step 0.** step=8 → samples 0,8,0,−8,0. step=0 → identical to the step=1 sequence.
- **Backpressure and enable.** sample_ready held low for 10 cycles with sample=5 → sample and sample_valid stay constant. Then en=0 → sample_valid drops. en=1 → sample 5 is re-presented, followed by 6.
- **Restart mid-walk.** step=7, assert restart during WALK → next cycle sample_valid=0, sample=0, quadrant=0. With en=1 the next samples are 0,7.
- **Reset mid-operation.** Assert rst at p=20 (sample = −4 at step=1) → all outputs at reset values next cycle, rom_adrs=0. After release the sequence restarts at 0.

Source files
------------

// File: rtl/sine_diff_gen.sv
// sine_diff_gen: full-wave sine sample generator driven by a quarter-wave difference table.
//
// The generator rebuilds the sine by walking an external combinational difference ROM
// and accumulating its entries into an unsigned magnitude. The magnitude is then
// presented as a signed sample through a valid/ready handshake. The phase advances by a
// programmable number of positions per sample.
//
// Ports:
//   clk           clock (single domain)
//   rst           synchronous reset, active-high
//   en            enable; starts or resumes sample generation
//   restart       synchronous phase clear to position 0
//   step          phase positions per output sample (0 is treated as 1)
//   rom_adrs      difference ROM address, decoded from the current phase
//   rom_diff      difference ROM data (same-cycle)
//   sample        signed two's-complement sine sample
//   sample_valid  sample is valid
//   sample_ready  downstream accepts the sample
//   quadrant      quadrant of the phase position of the presented sample
module sine_diff_gen #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DIFF_W = 16,
  parameter int unsigned MAG_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              restart,
  input  logic [ADDR_W+1:0] step,
  output logic [ADDR_W-1:0] rom_adrs,
  input  logic [DIFF_W-1:0] rom_diff,
  output logic [MAG_W:0]    sample,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic [1:0]        quadrant
);

  // Phase position is {quadrant, index}; it wraps modulo 4N through natural overflow.
  localparam int unsigned POS_W = ADDR_W + 2;
  localparam logic [POS_W-1:0] POS_ONE = POS_W'(1);
  localparam logic [MAG_W:0]   SMP_ONE = (MAG_W + 1)'(1);

  typedef enum logic [1:0] {
    StIdle,
    StOut,
    StWalk
  } state_e;

  state_e             state;
  logic [POS_W-1:0]   pos;
  logic [POS_W-1:0]   cnt;
  logic [MAG_W-1:0]   mag;

  logic [1:0]         pos_q;
  logic [ADDR_W-1:0]  pos_i;
  logic [MAG_W-1:0]   diff_ext;
  logic [POS_W-1:0]   pos_adv;
  logic [1:0]         q_adv;
  logic [MAG_W-1:0]   mag_adv;
  logic [MAG_W:0]     mag_ext;
  logic [MAG_W:0]     sample_adv;
  logic [POS_W-1:0]   step_eff;

  assign pos_q = pos[POS_W-1 -: 2];
  assign pos_i = pos[ADDR_W-1:0];

  // Odd quadrants walk the table backwards: N-1-i is the bitwise complement of i.
  assign rom_adrs = pos_q[0] ? ~pos_i : pos_i;

  // Fit the ROM word to the accumulator width; any excess ROM bits are dropped.
  if (DIFF_W >= MAG_W) begin : g_diff_trunc
    assign diff_ext = rom_diff[MAG_W-1:0];
  end else begin : g_diff_pad
    assign diff_ext = {{(MAG_W - DIFF_W){1'b0}}, rom_diff};
  end

  // One advance: rising quadrants add the increment, falling quadrants subtract it.
  always_comb begin
    pos_adv    = pos + POS_ONE;
    q_adv      = pos_adv[POS_W-1 -: 2];
    mag_adv    = pos_q[0] ? (mag - diff_ext) : (mag + diff_ext);
    mag_ext    = {1'b0, mag_adv};
    // The negative half-wave (quadrants 2 and 3) presents the negated magnitude.
    sample_adv = q_adv[1] ? (~mag_ext + SMP_ONE) : mag_ext;
    step_eff   = (step == '0) ? POS_ONE : step;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= StIdle;
      pos          <= '0;
      cnt          <= '0;
      mag          <= '0;
      sample       <= '0;
      quadrant     <= '0;
      sample_valid <= 1'b0;
    end else if (restart) begin
      // Abandons any walk in progress; partial accumulation is discarded.
      state        <= StIdle;
      pos          <= '0;
      cnt          <= '0;
      mag          <= '0;
      sample       <= '0;
      quadrant     <= '0;
      sample_valid <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          // The sample register already holds the value at the current phase.
          if (en) begin
            state        <= StOut;
            sample_valid <= 1'b1;
          end
        end
        StOut: begin
          if (sample_ready) begin
            cnt          <= step_eff;
            sample_valid <= 1'b0;
            state        <= StWalk;
          end else if (!en) begin
            // Sample stays in the register and is re-presented on re-enable.
            sample_valid <= 1'b0;
            state        <= StIdle;
          end
        end
        StWalk: begin
          // en is deliberately ignored until the walk completes.
          pos <= pos_adv;
          mag <= mag_adv;
          cnt <= cnt - POS_ONE;
          if (cnt == POS_ONE) begin
            sample       <= sample_adv;
            quadrant     <= q_adv;
            sample_valid <= 1'b1;
            state        <= StOut;
          end
        end
        default: begin
          state        <= StIdle;
          sample_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
